// File: rtl/iob_nco_sweep.sv
// Linear NCO period sweep sequencer driving the PERIOD_INT/PERIOD_FRAC write ports.
// Latency: one pair (int then frac) per update, minimum 3 cycles per update with dwell=0.
// Backpressure: waits indefinitely on each ready; wen and wdata are held until accepted.
module iob_nco_sweep #(
  parameter int DATA_W  = 32,
  parameter int DWELL_W = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [2*DATA_W-1:0]   start_period_i,
  input  logic [2*DATA_W-1:0]   end_period_i,
  input  logic [2*DATA_W-1:0]   step_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [DATA_W-1:0]     period_int_wdata_o,
  output logic                  period_int_wen_o,
  input  logic                  period_int_ready_i,
  output logic [DATA_W-1:0]     period_frac_wdata_o,
  output logic                  period_frac_wen_o,
  input  logic                  period_frac_ready_i,
  output logic                  nco_enable_o,
  output logic [2*DATA_W-1:0]   cur_period_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int PW = 2 * DATA_W;
  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_WR_INT, S_WR_FRAC, S_DWELL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      cur_q, cur_d;
  logic [PW-1:0]      end_q, end_d;
  logic [PW-1:0]      step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic               abort_q, abort_d;
  logic               nco_en_q, nco_en_d;
  logic [PW-1:0]      cur_period_q, cur_period_d;

  // One extra bit catches carry-out on the way up and borrow on the way down.
  logic [PW:0]   sum_w, diff_w;
  logic [PW-1:0] next_cur;

  assign sum_w  = {1'b0, cur_q} + {1'b0, step_q};
  assign diff_w = {1'b0, cur_q} - {1'b0, step_q};

  always_comb begin
    next_cur = end_q;
    if (dir_up_q) begin
      if (!sum_w[PW] && (sum_w[PW-1:0] <= end_q)) next_cur = sum_w[PW-1:0];
    end else begin
      if (!diff_w[PW] && (diff_w[PW-1:0] >= end_q)) next_cur = diff_w[PW-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    end_d        = end_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    cnt_d        = cnt_q;
    dir_up_d     = dir_up_q;
    abort_d      = abort_q;
    nco_en_d     = nco_en_q;
    cur_period_d = cur_period_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cur_d    = start_period_i;
          end_d    = end_period_i;
          step_d   = step_i;
          dwell_d  = dwell_i;
          dir_up_d = (end_period_i >= start_period_i);
          abort_d  = 1'b0;
          nco_en_d = 1'b0;
          state_d  = S_WR_INT;
        end
      end
      S_WR_INT: begin
        if (stop_i) abort_d = 1'b1;
        if (period_int_ready_i) state_d = S_WR_FRAC;
      end
      S_WR_FRAC: begin
        if (stop_i) abort_d = 1'b1;
        if (period_frac_ready_i) begin
          cur_period_d = cur_q;
          nco_en_d     = 1'b1;
          if ((cur_q == end_q) || (step_q == '0) || abort_q || stop_i) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = dwell_q;
            state_d = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          cur_d   = next_cur;
          state_d = S_WR_INT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      end_q        <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      dir_up_q     <= 1'b0;
      abort_q      <= 1'b0;
      nco_en_q     <= 1'b0;
      cur_period_q <= '0;
    end else if (cke_i) begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      dir_up_q     <= dir_up_d;
      abort_q      <= abort_d;
      nco_en_q     <= nco_en_d;
      cur_period_q <= cur_period_d;
    end
  end

  assign period_int_wdata_o  = cur_q[PW-1:DATA_W];
  assign period_frac_wdata_o = cur_q[DATA_W-1:0];
  assign period_int_wen_o    = (state_q == S_WR_INT);
  assign period_frac_wen_o   = (state_q == S_WR_FRAC);
  assign nco_enable_o        = nco_en_q;
  assign cur_period_o        = cur_period_q;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);

endmodule

// File: tb/tb_iob_nco_sweep.sv
// Bench for iob_nco_sweep: expected period pairs are queued at start and popped per handshake.
module tb_iob_nco_sweep;

  localparam int DATA_W  = 32;
  localparam int DWELL_W = 16;
  localparam int PW      = 2 * DATA_W;

  logic               clk_i = 1'b0;
  logic               arst_n_i;
  logic               cke_i;
  logic               start_i;
  logic               stop_i;
  logic [PW-1:0]      start_period_i;
  logic [PW-1:0]      end_period_i;
  logic [PW-1:0]      step_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [DATA_W-1:0]  period_int_wdata_o;
  logic               period_int_wen_o;
  logic               period_int_ready_i;
  logic [DATA_W-1:0]  period_frac_wdata_o;
  logic               period_frac_wen_o;
  logic               period_frac_ready_i;
  logic               nco_enable_o;
  logic [PW-1:0]      cur_period_o;
  logic               busy_o;
  logic               done_o;

  iob_nco_sweep #(.DATA_W(DATA_W), .DWELL_W(DWELL_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .start_i(start_i), .stop_i(stop_i),
    .start_period_i(start_period_i), .end_period_i(end_period_i),
    .step_i(step_i), .dwell_i(dwell_i),
    .period_int_wdata_o(period_int_wdata_o), .period_int_wen_o(period_int_wen_o),
    .period_int_ready_i(period_int_ready_i),
    .period_frac_wdata_o(period_frac_wdata_o), .period_frac_wen_o(period_frac_wen_o),
    .period_frac_ready_i(period_frac_ready_i),
    .nco_enable_o(nco_enable_o), .cur_period_o(cur_period_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            frac_xfers = 0;
  bit            pending_int = 0;
  logic [PW-1:0] exp_q[$];
  int            int_cyc_q[$];

  always @(posedge clk_i) cyc++;

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (period_int_wen_o && period_int_ready_i) begin
        tests++;
        if (exp_q.size() == 0 || pending_int) begin
          fails++;
          $display("FAIL int_write: unexpected int write %0h (queued %0d, pending %0d)",
                   period_int_wdata_o, exp_q.size(), pending_int);
        end else if (period_int_wdata_o !== exp_q[0][PW-1:DATA_W]) begin
          fails++;
          $display("FAIL int_write: got %0h expected %0h", period_int_wdata_o, exp_q[0][PW-1:DATA_W]);
        end
        pending_int = 1;
        int_cyc_q.push_back(cyc);
      end
      if (period_frac_wen_o && period_frac_ready_i) begin
        tests++;
        if (exp_q.size() == 0 || !pending_int) begin
          fails++;
          $display("FAIL frac_write: unexpected frac write %0h (queued %0d, pending %0d)",
                   period_frac_wdata_o, exp_q.size(), pending_int);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          if (period_frac_wdata_o !== e[DATA_W-1:0]) begin
            fails++;
            $display("FAIL frac_write: got %0h expected %0h", period_frac_wdata_o, e[DATA_W-1:0]);
          end
        end
        pending_int = 0;
        frac_xfers++;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic push_model(input logic [PW-1:0] s, input logic [PW-1:0] e,
                            input logic [PW-1:0] st, input int max_pairs);
    logic [PW-1:0] cur;
    logic [PW:0]   t;
    int            n;
    cur = s;
    n   = 0;
    while (n < max_pairs) begin
      exp_q.push_back(cur);
      n++;
      if (cur == e || st == '0) break;
      if (e >= s) begin
        t   = {1'b0, cur} + {1'b0, st};
        cur = (t[PW] || t[PW-1:0] > e) ? e : t[PW-1:0];
      end else begin
        t   = {1'b0, cur} - {1'b0, st};
        cur = (t[PW] || t[PW-1:0] < e) ? e : t[PW-1:0];
      end
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic kick(input logic [PW-1:0] s, input logic [PW-1:0] e, input logic [PW-1:0] st,
                      input logic [DWELL_W-1:0] dw, input bit with_stop);
    start_period_i = s;
    end_period_i   = e;
    step_i         = st;
    dwell_i        = dw;
    start_i        = 1'b1;
    stop_i         = with_stop;
    tick();
    start_i        = 1'b0;
    stop_i         = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    tests++;
    if (done_cnt != base + 1) begin
      fails++;
      $display("FAIL %s_done: done pulses %0d, required 1", name, done_cnt - base);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pairs: %0d expected pairs never written", name, exp_q.size());
    end
    exp_q.delete();
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy: busy_o=%0b after done, required 0", name, busy_o);
    end
  endtask

  task automatic wait_frac(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frac_xfers < target && n < budget) begin
      tick();
      n++;
    end
    if (frac_xfers < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: frac writes %0d, required %0d", name, frac_xfers, target);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({busy_o, done_o, period_int_wen_o, period_frac_wen_o, nco_enable_o} !== 5'b0) begin
      fails++;
      $display("FAIL %s_ctl: busy/done/iwen/fwen/en=%05b required 00000", name,
               {busy_o, done_o, period_int_wen_o, period_frac_wen_o, nco_enable_o});
    end
    tests++;
    if (cur_period_o !== '0) begin
      fails++;
      $display("FAIL %s_cur: cur_period_o=%0h required 0", name, cur_period_o);
    end
    tests++;
    if (period_int_wdata_o !== '0 || period_frac_wdata_o !== '0) begin
      fails++;
      $display("FAIL %s_wdata: int=%0h frac=%0h required 0", name, period_int_wdata_o, period_frac_wdata_o);
    end
  endtask

  task automatic test_reset;
    arst_n_i = 1'b0; cke_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    start_period_i = '0; end_period_i = '0; step_i = '0; dwell_i = '0;
    period_int_ready_i = 1'b1; period_frac_ready_i = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    arst_n_i = 1'b1;
    repeat (2) tick();
    check_idle_outputs("post_reset");
  endtask

  task automatic test_up_sweep;
    int b, f;
    b = done_cnt; f = frac_xfers;
    push_model(64'h5_00000000, 64'h6_00000000, 64'h0_40000000, 100);
    kick(64'h5_00000000, 64'h6_00000000, 64'h0_40000000, 16'd3, 1'b0);
    tests++;
    if (busy_o !== 1'b1 || nco_enable_o !== 1'b0) begin
      fails++;
      $display("FAIL up_start: busy=%0b en=%0b required 1/0", busy_o, nco_enable_o);
    end
    wait_frac(f + 1, 50, "up_first");
    tests++;
    if (nco_enable_o !== 1'b1) begin
      fails++;
      $display("FAIL up_enable: nco_enable_o=%0b after first pair, required 1", nco_enable_o);
    end
    wait_done(b, 200, "up");
    tests++;
    if (frac_xfers - f != 5 || cur_period_o !== 64'h6_00000000 || nco_enable_o !== 1'b1) begin
      fails++;
      $display("FAIL up_result: pairs=%0d cur=%0h en=%0b required 5/600000000/1",
               frac_xfers - f, cur_period_o, nco_enable_o);
    end
  endtask

  task automatic test_down_sweep;
    int b, f;
    b = done_cnt; f = frac_xfers;
    push_model(64'hA_00000000, 64'h8_80000000, 64'h1_00000000, 100);
    kick(64'hA_00000000, 64'h8_80000000, 64'h1_00000000, 16'd1, 1'b0);
    tests++;
    if (nco_enable_o !== 1'b0) begin
      fails++;
      $display("FAIL down_enable_clear: nco_enable_o=%0b after start, required 0", nco_enable_o);
    end
    wait_done(b, 200, "down");
    tests++;
    if (frac_xfers - f != 3 || cur_period_o !== 64'h8_80000000) begin
      fails++;
      $display("FAIL down_result: pairs=%0d cur=%0h required 3/880000000", frac_xfers - f, cur_period_o);
    end
  endtask

  task automatic test_backpressure;
    int b, f;
    logic [DATA_W-1:0] d0;
    b = done_cnt; f = frac_xfers;
    push_model(64'h1_00000000, 64'h2_00000000, 64'h0_80000000, 100);
    kick(64'h1_00000000, 64'h2_00000000, 64'h0_80000000, 16'd2, 1'b0);
    wait_frac(f + 1, 50, "bp_first");
    period_frac_ready_i = 1'b0;
    for (int n = 0; n < 50 && !period_frac_wen_o; n++) tick();
    d0 = period_frac_wdata_o;
    for (int k = 0; k < 7; k++) begin
      tick();
      tests++;
      if (!period_frac_wen_o || period_int_wen_o || period_frac_wdata_o !== 32'h80000000 ||
          period_frac_wdata_o !== d0 || cur_period_o !== 64'h1_00000000) begin
        fails++;
        $display("FAIL bp_hold: fwen=%0b iwen=%0b fdata=%0h cur=%0h required 1/0/80000000/100000000",
                 period_frac_wen_o, period_int_wen_o, period_frac_wdata_o, cur_period_o);
      end
    end
    period_frac_ready_i = 1'b1;
    tick();
    tests++;
    if (cur_period_o !== 64'h1_80000000) begin
      fails++;
      $display("FAIL bp_commit: cur_period_o=%0h required 180000000", cur_period_o);
    end
    wait_done(b, 200, "bp");
  endtask

  task automatic test_abort;
    int b, f;
    b = done_cnt; f = frac_xfers;
    push_model(64'h0_00000000, 64'h10_00000000, 64'h1_00000000, 3);
    kick(64'h0_00000000, 64'h10_00000000, 64'h1_00000000, 16'd2, 1'b0);
    wait_frac(f + 2, 100, "abort_second");
    period_int_ready_i = 1'b0;
    for (int n = 0; n < 50 && !period_int_wen_o; n++) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    period_int_ready_i = 1'b1;
    wait_done(b, 50, "abort");
    tests++;
    if (frac_xfers - f != 3 || cur_period_o !== 64'h2_00000000) begin
      fails++;
      $display("FAIL abort_result: pairs=%0d cur=%0h required 3/200000000", frac_xfers - f, cur_period_o);
    end
  endtask

  task automatic test_edges;
    int b, f;
    // step = 0: one pair only
    b = done_cnt; f = frac_xfers;
    push_model(64'h3_00000000, 64'h9_00000000, 64'h0, 100);
    kick(64'h3_00000000, 64'h9_00000000, 64'h0, 16'd0, 1'b0);
    wait_done(b, 50, "step0");
    tests++;
    if (frac_xfers - f != 1) begin
      fails++;
      $display("FAIL step0_pairs: pairs=%0d required 1", frac_xfers - f);
    end
    // start == end, with a simultaneous stop that must lose to start
    b = done_cnt; f = frac_xfers;
    push_model(64'h7_12345678, 64'h7_12345678, 64'h1, 100);
    kick(64'h7_12345678, 64'h7_12345678, 64'h1, 16'd0, 1'b1);
    wait_done(b, 50, "equal");
    tests++;
    if (frac_xfers - f != 1 || cur_period_o !== 64'h7_12345678) begin
      fails++;
      $display("FAIL equal_result: pairs=%0d cur=%0h required 1/712345678", frac_xfers - f, cur_period_o);
    end
    // dwell = 0: updates every 3 cycles; a start while busy is ignored
    b = done_cnt;
    int_cyc_q.delete();
    push_model(64'h0, 64'h0_00000003, 64'h0_00000001, 100);
    kick(64'h0, 64'h0_00000003, 64'h0_00000001, 16'd0, 1'b1);
    kick(64'h63_00000000, 64'h0, 64'h1, 16'd0, 1'b0);
    wait_done(b, 50, "dwell0");
    tests++;
    if (int_cyc_q.size() != 4) begin
      fails++;
      $display("FAIL dwell0_count: int writes=%0d required 4", int_cyc_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (int_cyc_q[i] - int_cyc_q[i-1] != 3) begin
          fails++;
          $display("FAIL dwell0_spacing: gap=%0d required 3", int_cyc_q[i] - int_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int b, f;
    f = frac_xfers;
    push_model(64'h64_00000000, 64'h0, 64'h1_00000000, 2);
    kick(64'h64_00000000, 64'h0, 64'h1_00000000, 16'd50, 1'b0);
    wait_frac(f + 1, 50, "rmid_first");
    repeat (5) tick();
    #2;
    arst_n_i = 1'b0;
    #1;
    check_idle_outputs("rmid_async");
    exp_q.delete();
    pending_int = 0;
    repeat (2) tick();
    arst_n_i = 1'b1;
    tick();
    b = done_cnt; f = frac_xfers;
    push_model(64'h2_00000000, 64'h3_00000000, 64'h0_80000000, 100);
    kick(64'h2_00000000, 64'h3_00000000, 64'h0_80000000, 16'd1, 1'b0);
    wait_done(b, 100, "rmid_rerun");
    tests++;
    if (frac_xfers - f != 3 || cur_period_o !== 64'h3_00000000 || nco_enable_o !== 1'b1) begin
      fails++;
      $display("FAIL rmid_result: pairs=%0d cur=%0h en=%0b required 3/300000000/1",
               frac_xfers - f, cur_period_o, nco_enable_o);
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_backpressure();
    test_abort();
    test_edges();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
